// File: rtl/mc_mem_port.sv
// Memory-side responder for the multicycle MIPS core: turns fetch/data stage
// requests into one outstanding req/ack bus transaction with a timeout.
module mc_mem_port #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_enable,
  input  logic        memory_enable,
  input  logic        is_store,
  input  logic [31:0] pc,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] instr_out,
  output logic [31:0] rdata_out,
  output logic        done,
  output logic        error,
  output logic        busy,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t        state;
  logic          kind_fetch;
  logic [CW-1:0] cnt;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; the async reset clears each register including the
  // output data holders, since their reset value is visible to the core.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      kind_fetch <= 1'b0;
      cnt        <= '0;
      instr_out  <= '0;
      rdata_out  <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      busy       <= 1'b0;
      bus_req    <= 1'b0;
      bus_addr   <= '0;
      bus_we     <= 1'b0;
      bus_wdata  <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          // Fetch has priority; a simultaneous data request is dropped.
          if (fetch_enable) begin
            bus_addr   <= pc;
            bus_we     <= 1'b0;
            kind_fetch <= 1'b1;
            bus_req    <= 1'b1;
            busy       <= 1'b1;
            state      <= BUS;
          end else if (memory_enable) begin
            bus_addr   <= addr;
            bus_wdata  <= wdata;
            bus_we     <= is_store;
            kind_fetch <= 1'b0;
            bus_req    <= 1'b1;
            busy       <= 1'b1;
            state      <= BUS;
          end
        end
        BUS: begin
          if (bus_ack) begin
            if (kind_fetch)   instr_out <= bus_rdata;
            else if (!bus_we) rdata_out <= bus_rdata;
            bus_req <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else if (cnt == CNT_LAST) begin
            cnt     <= cnt + CW'(1);
            bus_req <= 1'b0;
            done    <= 1'b1;
            error   <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          cnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          bus_req <= 1'b0;
          busy    <= 1'b0;
          cnt     <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_mem_port.sv
// Self-checking bench for mc_mem_port: transaction-level model plus directed
// scenarios with literal expectations, then randomized traffic.
module tb_mc_mem_port;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_enable, memory_enable, is_store;
  logic [31:0] pc, addr, wdata;
  logic [31:0] instr_out, rdata_out;
  logic        done, error, busy, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int vectors = 0;
  int miscompares = 0;
  int done_count = 0;

  mc_mem_port #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .fetch_enable(fetch_enable), .memory_enable(memory_enable), .is_store(is_store),
    .pc(pc), .addr(addr), .wdata(wdata),
    .instr_out(instr_out), .rdata_out(rdata_out),
    .done(done), .error(error), .busy(busy),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: m_age is the number of the bus cycle currently
  // in progress (0 = no request on the bus), m_done marks the completion cycle.
  int          m_age;
  logic        m_done, m_err, m_fetch, m_we;
  logic [31:0] m_instr, m_rdata, m_addr, m_wdata;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_age <= 0; m_done <= 0; m_err <= 0; m_fetch <= 0; m_we <= 0;
      m_instr <= 0; m_rdata <= 0; m_addr <= 0; m_wdata <= 0;
    end else if (m_done) begin
      m_done <= 0;
      m_err  <= 0;
    end else if (m_age > 0) begin
      if (bus_ack) begin
        if (m_fetch)    m_instr <= bus_rdata;
        else if (!m_we) m_rdata <= bus_rdata;
        m_age  <= 0;
        m_done <= 1;
      end else if (m_age == TIMEOUT) begin
        m_age  <= 0;
        m_done <= 1;
        m_err  <= 1;
      end else begin
        m_age <= m_age + 1;
      end
    end else if (fetch_enable) begin
      m_addr <= pc; m_we <= 0; m_fetch <= 1; m_age <= 1;
    end else if (memory_enable) begin
      m_addr <= addr; m_wdata <= wdata; m_we <= is_store; m_fetch <= 0; m_age <= 1;
    end
  end

  always @(negedge clk) begin
    check("bus_req", bus_req, m_age > 0);
    check("busy", busy, (m_age > 0) || m_done);
    check("done", done, m_done);
    check("error", error, m_err);
    check("bus_addr", bus_addr, m_addr);
    check("bus_we", bus_we, m_we);
    check("bus_wdata", bus_wdata, m_wdata);
    check("instr_out", instr_out, m_instr);
    check("rdata_out", rdata_out, m_rdata);
    if (done === 1'b1) done_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fetch_enable = 0; memory_enable = 0; is_store = 0; bus_ack = 0;
    pc = 0; addr = 0; wdata = 0; bus_rdata = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    int n;
    clear_inputs();
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    check("reset bus_req", bus_req, 0);
    check("reset busy", busy, 0);
    check("reset instr_out", instr_out, 0);
    check("reset bus_addr", bus_addr, 0);
    reset = 0;
    tick();

    // Fetch with ack in the third bus cycle
    fetch_enable = 1; pc = 32'h0040_0010;
    tick();
    fetch_enable = 0;
    check("fetch bus_req", bus_req, 1);
    check("fetch bus_addr", bus_addr, 32'h0040_0010);
    check("fetch bus_we", bus_we, 0);
    tick();
    tick();
    bus_ack = 1; bus_rdata = 32'h8C08_0004;
    tick();
    bus_ack = 0;
    check("fetch done", done, 1);
    check("fetch error", error, 0);
    check("fetch instr_out", instr_out, 32'h8C08_0004);
    check("fetch rdata_out", rdata_out, 0);
    check("model instr", m_instr, 32'h8C08_0004);
    tick();
    check("fetch idle busy", busy, 0);

    // Load acked in cycle 1
    memory_enable = 1; is_store = 0; addr = 32'h1000_0000;
    tick();
    memory_enable = 0;
    check("load bus_addr", bus_addr, 32'h1000_0000);
    bus_ack = 1; bus_rdata = 32'hDEAD_BEEF;
    tick();
    bus_ack = 0;
    check("load done", done, 1);
    check("load rdata_out", rdata_out, 32'hDEAD_BEEF);
    tick();

    // Store leaves both read registers alone
    memory_enable = 1; is_store = 1; addr = 32'h1000_0004; wdata = 32'h1234_5678;
    tick();
    memory_enable = 0; is_store = 0;
    check("store bus_we", bus_we, 1);
    check("store bus_wdata", bus_wdata, 32'h1234_5678);
    bus_ack = 1; bus_rdata = 32'hFFFF_FFFF;
    tick();
    bus_ack = 0;
    check("store done", done, 1);
    check("store rdata_out", rdata_out, 32'hDEAD_BEEF);
    check("store instr_out", instr_out, 32'h8C08_0004);
    tick();

    // Simultaneous enables: fetch wins, one transaction only
    d0 = done_count;
    fetch_enable = 1; memory_enable = 1; pc = 32'h4; addr = 32'h8;
    tick();
    fetch_enable = 0; memory_enable = 0;
    check("both bus_addr", bus_addr, 32'h4);
    check("both bus_we", bus_we, 0);
    bus_ack = 1; bus_rdata = 32'h2010_0001;
    tick();
    bus_ack = 0;
    repeat (5) tick();
    check("both done count", done_count - d0, 1);
    check("both bus_req", bus_req, 0);

    // Timeout: request held TIMEOUT cycles, then done+error
    memory_enable = 1; is_store = 0; addr = 32'h20;
    tick();
    memory_enable = 0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      if (bus_req === 1'b1) n++;
      tick();
    end
    check("timeout req cycles", n, TIMEOUT);
    check("timeout done", done, 1);
    check("timeout error", error, 1);
    check("timeout rdata_out", rdata_out, 32'hDEAD_BEEF);
    check("timeout instr_out", instr_out, 32'h2010_0001);
    tick();
    check("timeout after done", done, 0);
    check("timeout after busy", busy, 0);
    fetch_enable = 1; pc = 32'h0040_0014;
    tick();
    fetch_enable = 0; bus_ack = 1; bus_rdata = 32'h0000_0020;
    tick();
    bus_ack = 0;
    check("post-timeout done", done, 1);
    check("post-timeout error", error, 0);
    check("post-timeout instr", instr_out, 32'h0000_0020);
    tick();

    // Busy lockout and stray ack in IDLE
    d0 = done_count;
    fetch_enable = 1; pc = 32'h100;
    tick();
    fetch_enable = 0;
    for (int i = 0; i < 3; i++) begin
      fetch_enable = 1; memory_enable = 1; pc = 32'h999; addr = 32'h888;
      tick();
      check("lockout bus_addr", bus_addr, 32'h100);
    end
    fetch_enable = 0; memory_enable = 0;
    bus_ack = 1; bus_rdata = 32'hABCD_0123;
    tick();
    bus_ack = 0;
    check("lockout done", done, 1);
    tick();
    bus_ack = 1;
    tick();
    bus_ack = 0;
    repeat (3) tick();
    check("lockout done count", done_count - d0, 1);
    check("lockout busy", busy, 0);

    // Reset two cycles into BUS
    fetch_enable = 1; pc = 32'h200;
    tick();
    fetch_enable = 0;
    tick();
    d0 = done_count;
    #2 reset = 1;
    #1;
    check("midreset bus_req", bus_req, 0);
    check("midreset busy", busy, 0);
    check("midreset bus_addr", bus_addr, 0);
    check("midreset instr_out", instr_out, 0);
    check("midreset rdata_out", rdata_out, 0);
    tick();
    reset = 0;
    repeat (3) tick();
    check("midreset no done", done_count - d0, 0);
    fetch_enable = 1; pc = 32'h300;
    tick();
    fetch_enable = 0;
    check("postreset bus_addr", bus_addr, 32'h300);
    bus_ack = 1; bus_rdata = 32'h1111_2222;
    tick();
    bus_ack = 0;
    check("postreset done", done, 1);
    check("postreset instr", instr_out, 32'h1111_2222);
    tick();

    // Randomized traffic against the model
    repeat (2000) begin
      fetch_enable  = ($urandom_range(0, 3) == 0);
      memory_enable = ($urandom_range(0, 2) == 0);
      is_store      = $urandom_range(0, 1);
      pc = $urandom; addr = $urandom; wdata = $urandom;
      bus_ack   = ($urandom_range(0, 2) == 0);
      bus_rdata = $urandom;
      if ($urandom_range(0, 399) == 0) begin
        #1 reset = 1;
        #1 reset = 0;
      end
      tick();
    end
    clear_inputs();
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
